// File: rtl/mdma_ram_fifo_pkg.sv
// Shared definitions for the MDMA RAM-backed FIFO controller.
package mdma_ram_fifo_pkg;

  localparam int DW    = 80;
  localparam int AW    = 9;
  localparam int DEPTH = 2 ** AW;

  // One output-buffer slot: RAM word plus the ECC flags that came with it.
  typedef struct packed {
    logic [DW-1:0] dat;
    logic          sbe;
    logic          dbe;
  } ob_ent_t;

endpackage

// File: rtl/mdma_ram_fifo_ob.sv
// Small shifting register FIFO that holds prefetched RAM words.
// Slot 0 is always the head, so the consumer sees a plain register.
module mdma_ram_fifo_ob
  import mdma_ram_fifo_pkg::*;
#(
  parameter int OB_D  = 4,
  parameter int CNT_W = $clog2(OB_D + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  ob_ent_t          push_ent_i,
  input  logic             pop_i,
  output ob_ent_t          head_o,
  output logic [CNT_W-1:0] cnt_o
);

  ob_ent_t          ent_q [OB_D];
  ob_ent_t          ent_d [OB_D];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] wr_idx_s;

  // Next-state: shift on pop, write the new word just above the surviving entries.
  always_comb begin
    ent_d    = ent_q;
    cnt_d    = cnt_q;
    wr_idx_s = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        2'b01: begin
          for (int i = 0; i < OB_D - 1; i++) ent_d[i] = ent_q[i+1];
          cnt_d = cnt_q - CNT_W'(1);
        end
        2'b11: begin
          for (int i = 0; i < OB_D - 1; i++) ent_d[i] = ent_q[i+1];
          wr_idx_s = cnt_q - CNT_W'(1);
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
      if (push_i) begin
        for (int i = 0; i < OB_D; i++) begin
          if (CNT_W'(i) == wr_idx_s) ent_d[i] = push_ent_i;
        end
      end else begin
        wr_idx_s = cnt_q;
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
      for (int i = 0; i < OB_D; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

  assign head_o = ent_q[0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/mdma_ram_fifo_ctl.sv
// FIFO controller for an ECC-protected simple-dual-port RAM with a prefetch
// output buffer that hides the RAM read latency, plus ECC error statistics.
module mdma_ram_fifo_ctl
  import mdma_ram_fifo_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int OB_D   = 4,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat,
  output logic          out_sbe,
  output logic          out_dbe,
  output logic [AW-1:0] wadr,
  output logic          wen,
  output logic [DW-1:0] wdat,
  output logic          ren,
  output logic [AW-1:0] radr,
  input  logic [DW-1:0] rdat,
  input  logic          rsbe,
  input  logic          rdbe,
  output logic [AW+1:0] occ,
  output logic [CW-1:0] sbe_cnt,
  output logic [CW-1:0] dbe_cnt,
  output logic          err_pulse
);

  localparam int          OBC_W    = $clog2(OB_D + 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       ram_cnt_q, ram_cnt_d;
  logic [OBC_W-1:0]  infl_q, infl_d;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic [CW-1:0]     sbe_cnt_q, sbe_cnt_d;
  logic [CW-1:0]     dbe_cnt_q, dbe_cnt_d;
  logic              err_pulse_q, err_pulse_d;

  logic              rdy_s, push_s, ren_s, ret_s, pop_s, vld_s;
  logic [OBC_W-1:0]  ob_cnt_s;
  logic [OBC_W:0]    ob_pend_s;
  ob_ent_t           ret_ent_s;
  ob_ent_t           head_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Handshake and read-issue decisions; OB slots already promised to in-flight reads count as used.
  always_comb begin
    ob_pend_s = {1'b0, ob_cnt_s} + {1'b0, infl_q};
    rdy_s     = ~rst & ~flush & (ram_cnt_q != FULL_CNT);
    push_s    = in_vld & rdy_s;
    ren_s     = ~rst & ~flush & (ram_cnt_q != {(AW + 1){1'b0}})
                & (ob_pend_s < (OBC_W + 1)'(OB_D));
    ret_s     = vpipe_q[RD_LAT-1];
    vld_s     = (ob_cnt_s != {OBC_W{1'b0}});
    pop_s     = vld_s & out_rdy & ~flush & ~rst;
    ret_ent_s = {rdat, rsbe, rdbe};
  end

  // Pointer, RAM-count, in-flight and read-latency pipe next state.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ram_cnt_d = ram_cnt_q;
    infl_d    = infl_q;
    vpipe_d   = vpipe_q;
    if (flush) begin
      wptr_d    = {AW{1'b0}};
      rptr_d    = {AW{1'b0}};
      ram_cnt_d = {(AW + 1){1'b0}};
      infl_d    = {OBC_W{1'b0}};
      vpipe_d   = {RD_LAT{1'b0}};
    end else begin
      if (push_s) wptr_d = wptr_q + AW'(1);
      else        wptr_d = wptr_q;
      if (ren_s)  rptr_d = rptr_q + AW'(1);
      else        rptr_d = rptr_q;
      case ({push_s, ren_s})
        2'b10:   ram_cnt_d = ram_cnt_q + (AW + 1)'(1);
        2'b01:   ram_cnt_d = ram_cnt_q - (AW + 1)'(1);
        default: ram_cnt_d = ram_cnt_q;
      endcase
      case ({ren_s, ret_s})
        2'b10:   infl_d = infl_q + OBC_W'(1);
        2'b01:   infl_d = infl_q - OBC_W'(1);
        default: infl_d = infl_q;
      endcase
      vpipe_d[0] = ren_s;
      for (int i = 1; i < RD_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
    end
  end

  // Error statistics: counters saturate and survive a flush.
  always_comb begin
    sbe_cnt_d   = sbe_cnt_q;
    dbe_cnt_d   = dbe_cnt_q;
    err_pulse_d = pop_s & (head_s.sbe | head_s.dbe);
    if (pop_s && head_s.sbe) sbe_cnt_d = sat_inc(sbe_cnt_q);
    else                     sbe_cnt_d = sbe_cnt_q;
    if (pop_s && head_s.dbe) dbe_cnt_d = sat_inc(dbe_cnt_q);
    else                     dbe_cnt_d = dbe_cnt_q;
  end

  // Control and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= {AW{1'b0}};
      rptr_q      <= {AW{1'b0}};
      ram_cnt_q   <= {(AW + 1){1'b0}};
      infl_q      <= {OBC_W{1'b0}};
      vpipe_q     <= {RD_LAT{1'b0}};
      sbe_cnt_q   <= {CW{1'b0}};
      dbe_cnt_q   <= {CW{1'b0}};
      err_pulse_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ram_cnt_q   <= ram_cnt_d;
      infl_q      <= infl_d;
      vpipe_q     <= vpipe_d;
      sbe_cnt_q   <= sbe_cnt_d;
      dbe_cnt_q   <= dbe_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  mdma_ram_fifo_ob #(
    .OB_D  (OB_D),
    .CNT_W (OBC_W)
  ) u_ob (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (flush),
    .push_i     (ret_s),
    .push_ent_i (ret_ent_s),
    .pop_i      (pop_s),
    .head_o     (head_s),
    .cnt_o      (ob_cnt_s)
  );

  assign in_rdy    = rdy_s;
  assign wen       = push_s;
  assign wadr      = wptr_q;
  assign wdat      = in_dat;
  assign ren       = ren_s;
  assign radr      = rptr_q;
  assign out_vld   = vld_s;
  assign out_dat   = head_s.dat;
  assign out_sbe   = head_s.sbe;
  assign out_dbe   = head_s.dbe;
  assign occ       = (AW + 2)'(ram_cnt_q) + (AW + 2)'(infl_q) + (AW + 2)'(ob_cnt_s);
  assign sbe_cnt   = sbe_cnt_q;
  assign dbe_cnt   = dbe_cnt_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_mdma_ram_fifo_ctl.sv
// Self-checking bench for mdma_ram_fifo_ctl with a behavioural ECC RAM model.
module tb_mdma_ram_fifo_ctl;
  import mdma_ram_fifo_pkg::*;

  localparam int RD_LAT = 2;

  logic          clk, rst, flush, in_vld, in_rdy, out_vld, out_rdy;
  logic [DW-1:0] in_dat, out_dat, wdat, rdat;
  logic          out_sbe, out_dbe, wen, ren, rsbe, rdbe, err_pulse;
  logic [AW-1:0] wadr, radr;
  logic [AW+1:0] occ;
  logic [15:0]   sbe_cnt, dbe_cnt;

  mdma_ram_fifo_ctl #(.RD_LAT(RD_LAT), .OB_D(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
    .out_sbe(out_sbe), .out_dbe(out_dbe),
    .wadr(wadr), .wen(wen), .wdat(wdat),
    .ren(ren), .radr(radr), .rdat(rdat), .rsbe(rsbe), .rdbe(rdbe),
    .occ(occ), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: two-stage read pipe, error flags injected by read index.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] p0_dat;
  logic          p0_sbe, p0_dbe;
  int            rd_idx;
  int            inj_sbe_idx = -1;
  int            inj_dbe_idx = -1;
  bit            inj_sbe_all = 1'b0;

  always @(posedge clk) begin
    if (wen) mem[wadr] <= wdat;
    if (rst) rd_idx <= 0;
    else if (ren) rd_idx <= rd_idx + 1;
    p0_dat <= mem[radr];
    p0_sbe <= ren && (inj_sbe_all || rd_idx == inj_sbe_idx);
    p0_dbe <= ren && (rd_idx == inj_dbe_idx);
    rdat   <= p0_dat;
    rsbe   <= p0_sbe;
    rdbe   <= p0_dbe;
  end

  int checks = 0;
  int errors = 0;
  int pop_idx, pulses, pops;
  logic [DW-1:0] sb [$];

  typedef struct {
    logic          vld;
    logic [DW-1:0] dat;
    logic          rdy;
    logic          e_in_rdy;
    logic          e_wen;
    logic          e_ren;
    logic          e_vld;
    logic [DW-1:0] e_dat;
    logic [AW+1:0] e_occ;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  // Scoreboard bookkeeping for the current cycle, called at the falling edge.
  task automatic observe();
    logic [DW-1:0] e;
    if (err_pulse === 1'b1) pulses++;
    if (!flush && in_vld && in_rdy) sb.push_back(in_dat);
    if (!flush && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=out_vld 1 expected=no word pending");
      end else begin
        e = sb.pop_front();
        chk("pop_dat", out_dat, e);
        chk("pop_sbe", out_sbe, inj_sbe_all || pop_idx == inj_sbe_idx);
        chk("pop_dbe", out_dbe, pop_idx == inj_dbe_idx);
      end
      pop_idx++;
      pops++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; in_dat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", in_rdy, 1'b0);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_wen", wen, 1'b0);
    chk("rst_ren", ren, 1'b0);
    chk("rst_occ", occ, 11'd0);
    chk("rst_sbe_cnt", sbe_cnt, 16'd0);
    chk("rst_dbe_cnt", dbe_cnt, 16'd0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    pop_idx = 0; pulses = 0; pops = 0;
  endtask

  task automatic drain(input string nm, input int bound);
    in_vld = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < bound && sb.size() != 0; i++) tick();
    repeat (3) tick();
    chk({nm, "_sb_empty"}, sb.size(), 0);
    @(negedge clk);
    chk({nm, "_occ0"}, occ, 11'd0);
    chk({nm, "_vld0"}, out_vld, 1'b0);
    observe();
    @(posedge clk);
    #1;
  endtask

  // Streams in_vld/out_rdy both high for n cycles and checks for gaps.
  task automatic stream(input string nm, input int n, input bit check_wrap);
    bit seen = 1'b0, wwrap = 1'b0, rwrap = 1'b0;
    int bubbles = 0, stalls = 0;
    logic [AW-1:0] lw = '0, lr = '0;
    in_vld = 1'b1; out_rdy = 1'b1;
    for (int c = 0; c < n; c++) begin
      in_dat = rnd();
      @(negedge clk);
      if (out_vld) seen = 1'b1;
      else if (seen) bubbles++;
      if (!in_rdy) stalls++;
      if (wen) begin
        if (lw == 9'd511 && wadr == 9'd0) wwrap = 1'b1;
        lw = wadr;
      end
      if (ren) begin
        if (lr == 9'd511 && radr == 9'd0) rwrap = 1'b1;
        lr = radr;
      end
      observe();
      @(posedge clk);
      #1;
    end
    chk({nm, "_seen"}, seen, 1'b1);
    chk({nm, "_bubbles"}, bubbles, 0);
    chk({nm, "_stalls"}, stalls, 0);
    if (check_wrap) begin
      chk({nm, "_wadr_wrap"}, wwrap, 1'b1);
      chk({nm, "_radr_wrap"}, rwrap, 1'b1);
    end
  endtask

  initial begin
    bit stop;
    int p0;

    //          vld   dat     rdy   in_rdy wen  ren   vld   e_dat   occ
    vt[0] = '{1'b1, 80'h1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 80'h0, 11'd0};
    vt[1] = '{1'b1, 80'h2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 80'h0, 11'd1};
    vt[2] = '{1'b1, 80'h3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 80'h0, 11'd2};
    vt[3] = '{1'b0, 80'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 80'h0, 11'd3};
    vt[4] = '{1'b0, 80'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 80'h1, 11'd3};
    vt[5] = '{1'b0, 80'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 80'h2, 11'd2};
    vt[6] = '{1'b0, 80'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 80'h3, 11'd1};
    vt[7] = '{1'b0, 80'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 80'h0, 11'd0};
    vt[8] = '{1'b0, 80'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 80'h0, 11'd0};

    // Basic latency/order vectors.
    do_reset();
    for (int r = 0; r < 9; r++) begin
      in_vld = vt[r].vld; in_dat = vt[r].dat; out_rdy = vt[r].rdy;
      @(negedge clk);
      chk($sformatf("t%0d_in_rdy", r), in_rdy, vt[r].e_in_rdy);
      chk($sformatf("t%0d_wen", r), wen, vt[r].e_wen);
      chk($sformatf("t%0d_ren", r), ren, vt[r].e_ren);
      chk($sformatf("t%0d_out_vld", r), out_vld, vt[r].e_vld);
      if (vt[r].e_vld) chk($sformatf("t%0d_out_dat", r), out_dat, vt[r].e_dat);
      chk($sformatf("t%0d_occ", r), occ, vt[r].e_occ);
      observe();
      @(posedge clk);
      #1;
    end
    chk("t_pops", pops, 3);

    // Fill to capacity with the consumer stalled, then drain.
    do_reset();
    out_rdy = 1'b0; in_vld = 1'b1; stop = 1'b0;
    for (int c = 0; c < 600 && !stop; c++) begin
      in_dat = rnd();
      @(negedge clk);
      if (!in_rdy) stop = 1'b1;
      observe();
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("full_count", sb.size(), 516);
    chk("full_occ", occ, 11'd516);
    chk("full_in_rdy", in_rdy, 1'b0);
    chk("full_out_vld", out_vld, 1'b1);
    if (sb.size() != 0) chk("full_head", out_dat, sb[0]);
    observe();
    @(posedge clk);
    #1;
    drain("full_drain", 700);

    // Sustained streaming with pointer wrap.
    do_reset();
    stream("strm", 2000, 1'b1);
    drain("strm_drain", 100);

    // ECC flag delivery and counting.
    do_reset();
    inj_sbe_idx = 2; inj_dbe_idx = 4;
    stream("ecc", 8, 1'b0);
    drain("ecc_drain", 50);
    chk("ecc_sbe_cnt", sbe_cnt, 16'd1);
    chk("ecc_dbe_cnt", dbe_cnt, 16'd1);
    chk("ecc_pulses", pulses, 2);

    // Saturation of the single-bit error counter.
    inj_sbe_idx = -1; inj_dbe_idx = -1; inj_sbe_all = 1'b1;
    stream("sat", 65537, 1'b0);
    drain("sat_drain", 50);
    chk("sat_sbe_cnt", sbe_cnt, 16'hFFFF);
    chk("sat_dbe_cnt", dbe_cnt, 16'd1);
    inj_sbe_all = 1'b0;

    // Flush with reads in flight and the output buffer committed.
    do_reset();
    out_rdy = 1'b0; in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_dat = DW'(i + 1);
      tick();
    end
    flush = 1'b1; in_dat = 80'h55; out_rdy = 1'b1;
    @(negedge clk);
    chk("fl_pre_occ", occ, 11'd5);
    chk("fl_pre_vld", out_vld, 1'b1);
    chk("fl_in_rdy", in_rdy, 1'b0);
    chk("fl_ren", ren, 1'b0);
    chk("fl_wen", wen, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_vld = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("fl_post_vld", out_vld, 1'b0);
    chk("fl_post_occ", occ, 11'd0);
    chk("fl_post_in_rdy", in_rdy, 1'b1);
    chk("fl_post_ren", ren, 1'b0);
    observe();
    @(posedge clk);
    #1;
    p0 = pops;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fl_no_late", out_vld, 1'b0);
      observe();
      @(posedge clk);
      #1;
    end
    in_vld = 1'b1; in_dat = 80'hAA;
    tick();
    drain("fl_drain", 20);
    chk("fl_pops", pops - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
